dh_modexp_engine: RTL and testbench

Sequential modular-exponentiation engine computing key = base^e mod p by constant-time MSB-first square-and-multiply. It sits directly upstream of the encryption stage. Its zero-extended 64-bit result feeds the encryption stage's `exp` input, and its held `done` level feeds `done_i_enc2`. The same `p` drives both blocks, so the downstream `exp mod p` reproduces `key` exactly.

---
 rtl/dh_pkg.sv | 25 ++
 rtl/dh_modmul.sv | 71 +++++++
 rtl/dh_modexp_engine.sv | 188 ++++++++++++++++++
 tb/tb_dh_modexp_engine.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dh_pkg.sv
// dh_pkg: shared definitions for the Diffie-Hellman modular-exponentiation
// slice. It holds the default operand widths, the engine FSM state type, and
// the latency constants that the engine is built to meet.
package dh_pkg;

  localparam int unsigned W_DEF = 32;   // modulus / operand width
  localparam int unsigned E_DEF = 32;   // exponent width

  // NEXT has no cycle of its own. Its decision is taken inside the MUL
  // completion cycle, and the member is kept so the state set stays complete.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    NEXT,
    FIN
  } state_t;

  // One issue cycle plus W shift-add iterations per modular multiply.
  localparam int unsigned MODMUL_LAT = W_DEF + 1;
  // Acceptance -> done: LOAD, E x (square + multiply), then FIN.
  localparam int unsigned MODEXP_LAT = 2 + 2 * E_DEF * (W_DEF + 1);

endpackage

// File: rtl/dh_modmul.sv
// dh_modmul: sequential (a*b) mod p by interleaved shift-add, MSB-first over
// the multiplier b. The unit never forms a full 2W product; its intermediates
// are W+2 bits wide.
//
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   go        issue: a/b/p are captured and the accumulator is cleared
//   a, b, p   multiplicand, multiplier and modulus (a < p is assumed)
//   rdy       high during the final iteration cycle
//   r         value that the final iteration produces. It is valid while
//             rdy=1, and the consumer registers it on that same edge.
//
// Latency: issue edge + W iteration edges = W+1 edges.
module dh_modmul
  import dh_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic         rdy,
  output logic [W-1:0] r
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  a_q, b_q, p_q, r_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [W+1:0]  t, t1;
  logic [W-1:0]  nxt;

  // r_q < p and a < p, so 2r + a < 3p. Two conditional subtractions are
  // therefore enough to bring the value back below p.
  always_comb begin
    t   = {1'b0, r_q, 1'b0} + (b_q[cnt_q] ? {2'b00, a_q} : '0);
    t1  = (t >= {2'b00, p_q}) ? (t - {2'b00, p_q}) : t;
    nxt = (t1 >= {2'b00, p_q}) ? W'(t1 - {2'b00, p_q}) : t1[W-1:0];
  end

  assign rdy = run_q && (cnt_q == '0);
  assign r   = nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (go) begin
      a_q   <= a;
      b_q   <= b;
      p_q   <= p;
      r_q   <= '0;
      cnt_q <= CW'(W - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      r_q <= nxt;
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/dh_modexp_engine.sv
// dh_modexp_engine: computes key = base^e mod p with constant-time, MSB-first
// square-and-multiply. A single dh_modmul unit is shared between the square
// and the multiply steps.
//
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   start      request, accepted when busy=0 (in IDLE)
//   base, e, p operands, captured on the acceptance edge (base < p)
//   busy       high from the cycle after acceptance until the final state
//   done       level, held until the next accepted start or reset
//   key        result, valid while done=1
//   exp_o      key zero-extended to 64 bits, for the downstream encryptor
//   err        invalid-modulus flag
//
// Build option: DH_MODEXP_PCHECK_EN. When it is defined, a modulus below 2
// skips the iteration and finishes at once with key=0 and err=1. When it is
// undefined, err stays 0 and every run takes the full latency.
module dh_modexp_engine
  import dh_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned E = E_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [E-1:0] e,
  input  logic [W-1:0] p,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] key,
  output logic [63:0]  exp_o,
  output logic         err
);

  localparam int unsigned IW = (E > 1) ? $clog2(E) : 1;

`ifdef DH_MODEXP_PCHECK_EN
  localparam bit PCHECK = 1'b1;
`else
  localparam bit PCHECK = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  base_q, base_d;
  logic [E-1:0]  e_q, e_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sq_q, sq_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          iss_q, iss_d;
  logic [W-1:0]  key_q, key_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          mm_go, mm_rdy;
  logic [W-1:0]  mm_a, mm_b, mm_r;
  logic          p_bad;

  dh_modmul #(.W(W)) u_modmul (
    .clk (clk),
    .rst (rst),
    .go  (mm_go),
    .a   (mm_a),
    .b   (mm_b),
    .p   (p_q),
    .rdy (mm_rdy),
    .r   (mm_r)
  );

  assign p_bad = (p_q < W'(2));

  // SQR and MUL each issue exactly once (iss_q), then wait for rdy. rdy
  // arrives W edges after the issue edge, which gives W+1 edges per phase.
  // The NEXT decision (finish or step the bit index) is folded into the
  // MUL completion edge, so no cycle is spent on it.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    e_d     = e_q;
    p_d     = p_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    idx_d   = idx_q;
    iss_d   = iss_q;
    key_d   = key_q;
    done_d  = done_q;
    err_d   = err_q;
    mm_go   = 1'b0;
    mm_a    = acc_q;
    mm_b    = acc_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base;
          e_d     = e;
          p_d     = p;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = (p_q == W'(1)) ? '0 : W'(1);
        idx_d   = IW'(E - 1);
        iss_d   = 1'b0;
        state_d = SQR;
        if (PCHECK && p_bad) begin
          acc_d   = '0;
          state_d = FIN;
        end
      end
      SQR: begin
        mm_go = !iss_q;
        mm_a  = acc_q;
        mm_b  = acc_q;
        if (!iss_q) iss_d = 1'b1;
        if (mm_rdy) begin
          sq_d    = mm_r;
          iss_d   = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        mm_go = !iss_q;
        mm_a  = sq_q;
        mm_b  = base_q;
        if (!iss_q) iss_d = 1'b1;
        if (mm_rdy) begin
          // The product is always formed; the exponent bit only picks which
          // value is kept, so timing is independent of e.
          acc_d = e_q[idx_q] ? mm_r : sq_q;
          iss_d = 1'b0;
          if (idx_q == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQR;
          end
        end
      end
      FIN: begin
        key_d   = acc_q;
        done_d  = 1'b1;
        err_d   = PCHECK && p_bad;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      e_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      sq_q    <= '0;
      idx_q   <= '0;
      iss_q   <= 1'b0;
      key_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      e_q     <= e_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      idx_q   <= idx_d;
      iss_q   <= iss_d;
      key_q   <= key_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == LOAD) || (state_q == SQR) || (state_q == MUL);
  assign done  = done_q;
  assign key   = key_q;
  assign exp_o = 64'(key_q);
  assign err   = err_q;

endmodule

// File: tb/tb_dh_modexp_engine.sv
// Bench for dh_modexp_engine at W=32, E=32. It applies a fixed vector table,
// then randomized operands checked against a modular-exponentiation model,
// then a mid-run reset sequence.
module tb_dh_modexp_engine;

  localparam int LAT_FULL = 2 + 2 * 32 * 33;   // 2114
  localparam int BOUND    = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base, e, p;
  logic        busy, done, err;
  logic [31:0] key;
  logic [63:0] exp_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dh_modexp_engine #(.W(32), .E(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .base  (base),
    .e     (e),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .key   (key),
    .exp_o (exp_o),
    .err   (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Plain left-to-right exponentiation with 64-bit arithmetic.
  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] ev,
                                             input logic [31:0] pv);
    longint unsigned r, bb, pp;
    pp = {32'd0, pv};
    bb = {32'd0, b};
    r  = 64'd1 % pp;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % pp;
      if (ev[i]) r = (r * bb) % pp;
    end
    return r[31:0];
  endfunction

  // Starts one operation, then scrambles the operand inputs to confirm that
  // the engine captured them. It optionally pulses start mid-run and counts
  // the edges until done plus the cycles with busy high.
  task automatic run_op(input logic [31:0] b, input logic [31:0] ev, input logic [31:0] pv,
                        input int pulse_at, output int lat, output int bcnt);
    base = b; e = ev; p = pv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = $urandom; e = $urandom; p = $urandom;
    check("done_clears_on_accept", {63'd0, done}, 64'd0);
    lat = 0; bcnt = 0;
    while (!done && lat < BOUND) begin
      if (busy) bcnt++;
      if (lat == pulse_at) begin
        base = 32'd5; e = 32'd6; p = 32'd23; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] b;
    logic [31:0] ev;
    logic [31:0] pv;
    logic [31:0] key;
    int          lat;
    logic        err;
    int          pulse;
  } vec_t;

  vec_t tv[7];

  initial begin
    int lat, bcnt;
    logic [31:0] kexp, held;
    logic [31:0] rb, re, rp;
    logic        perr;
    int          plat;

`ifdef DH_MODEXP_PCHECK_EN
    perr = 1'b1; plat = 2;
`else
    perr = 1'b0; plat = LAT_FULL;
`endif

    tv[0] = '{32'd5,  32'd6,  32'd23,          32'd8,  LAT_FULL, 1'b0, -1};
    tv[1] = '{32'd5,  32'd15, 32'd23,          32'd19, LAT_FULL, 1'b0, -1};
    tv[2] = '{32'd19, 32'd6,  32'd23,          32'd2,  LAT_FULL, 1'b0, -1};
    tv[3] = '{32'd8,  32'd15, 32'd23,          32'd2,  LAT_FULL, 1'b0, -1};
    tv[4] = '{32'd2,  32'd32, 32'd4294967291,  32'd5,  LAT_FULL, 1'b0, -1};
    tv[5] = '{32'd7,  32'd0,  32'd23,          32'd1,  LAT_FULL, 1'b0, 100};
    tv[6] = '{32'd0,  32'd5,  32'd1,           32'd0,  plat,     perr, -1};

    rst = 1'b0; start = 1'b0; base = '0; e = '0; p = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  {63'd0, busy}, 64'd0);
    check("reset_done",  {63'd0, done}, 64'd0);
    check("reset_key",   {32'd0, key},  64'd0);
    check("reset_exp_o", exp_o,         64'd0);
    check("reset_err",   {63'd0, err},  64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(tv[i].b, tv[i].ev, tv[i].pv, tv[i].pulse, lat, bcnt);
      check($sformatf("vec%0d_latency", i),   lat,                 tv[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), bcnt,              tv[i].lat - 1);
      check($sformatf("vec%0d_key", i),       {32'd0, key},        {32'd0, tv[i].key});
      check($sformatf("vec%0d_exp_o", i),     exp_o,               {32'd0, tv[i].key});
      check($sformatf("vec%0d_err", i),       {63'd0, err},        {63'd0, tv[i].err});
      held = key;
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_held", i), {63'd0, done}, 64'd1);
      check($sformatf("vec%0d_key_held", i),  {32'd0, key},  {32'd0, held});
    end

    for (int i = 0; i < 6; i++) begin
      rp = $urandom;
      if (rp < 32'd2) rp = 32'd97;
      rb = $urandom % rp;
      re = $urandom;
      kexp = ref_modexp(rb, re, rp);
      run_op(rb, re, rp, -1, lat, bcnt);
      check($sformatf("rnd%0d_latency", i), lat,          LAT_FULL);
      check($sformatf("rnd%0d_key", i),     {32'd0, key}, {32'd0, kexp});
      check($sformatf("rnd%0d_exp_o", i),   exp_o,        {32'd0, kexp});
      check($sformatf("rnd%0d_err", i),     {63'd0, err}, 64'd0);
    end

    // Reset lands in the middle of a run. The previous key is nonzero here,
    // so the reset visibly clears it.
    base = 32'd5; e = 32'd15; p = 32'd23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (999) @(posedge clk);
    #1;
    check("midrun_busy_before_reset", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    check("midrun_reset_busy",  {63'd0, busy}, 64'd0);
    check("midrun_reset_done",  {63'd0, done}, 64'd0);
    check("midrun_reset_key",   {32'd0, key},  64'd0);
    check("midrun_reset_exp_o", exp_o,         64'd0);
    check("midrun_reset_err",   {63'd0, err},  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(32'd5, 32'd15, 32'd23, -1, lat, bcnt);
    check("post_reset_latency", lat,          LAT_FULL);
    check("post_reset_key",     {32'd0, key}, 64'd19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
